a2d_intf: RTL and testbench
===========================

A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL have port: clk  input  1  system clock (50MHz); all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: nxt  input  1  one-cycle request to convert next channel in round-robin.
REQ-004 SHALL have port: wrt  output  1  one-cycle pulse starting an SPI transaction on the SPI master.
REQ-005 SHALL have port: cmd  output  16  SPI command word, {2'b00, chnl[2:0], 11'h000}.
REQ-006 SHALL have port: done  input  1  one-cycle pulse from SPI master, transaction complete.
REQ-007 SHALL have port: rd_data  input  16  SPI receive word; bits [11:0] are the conversion.
REQ-008 SHALL have ports: lft_ld, rght_ld, steer_pot, batt  output  12 each  latest readings; lft_ld/rght_ld feed steer_en.
REQ-009 SHALL have port: cnv_cmplt  output  1  one-cycle pulse after any reading register updates.
REQ-010 Clocking SHALL be a single clock, clk; reset SHALL be synchronous, active-high, on port rst.

Function
REQ-011 Channel sequence SHALL be lft_ld=0, rght_ld=4, steer_pot=5, batt=6, then wrap to lft_ld; 2-bit round-robin pointer.
REQ-012 State machine SHALL have states IDLE, CMD, GAP, READ.
REQ-013 IDLE: nxt=1 at edge -> CMD; wrt=1 for exactly the following cycle; cmd loaded with current channel.
REQ-014 CMD: done=1 -> GAP; otherwise hold CMD.
REQ-015 GAP: SHALL last exactly one cycle, then -> READ with wrt pulsed one cycle; cmd unchanged.
REQ-016 READ: done=1 -> IDLE; same edge SHALL write rd_data[11:0] to the register of the current channel and advance the pointer.
REQ-017 cnv_cmplt SHALL pulse in the cycle after the READ->IDLE edge; wrt and cnv_cmplt SHALL be registered outputs.
REQ-018 Latency nxt to cnv_cmplt SHALL be 2 SPI transactions + 4 cycles when the SPI master is ready.
REQ-019 nxt outside IDLE SHALL be ignored (not queued).
REQ-020 done in IDLE or GAP SHALL be ignored.
REQ-021 nxt and done both high in IDLE SHALL start a conversion; done has no effect.
REQ-022 Only the addressed reading register SHALL change per conversion; others hold.
REQ-023 cmd SHALL hold its value between conversions.

Reset
REQ-024 rst=1 SHALL force IDLE, pointer=0 (lft), cmd=16'h0000, wrt=0, cnv_cmplt=0, all four readings=12'h000.
REQ-025 rst asserted mid-transaction SHALL abort it; a done arriving after reset release SHALL be ignored in IDLE.
REQ-026 rst SHALL dominate nxt and done in the same cycle.

Configuration
REQ-027 Macro A2D_LD_AVG_EN defined: lft_ld/rght_ld SHALL update as (old + new) >> 1 using a 13-bit sum, truncating; steer_pot/batt stay raw.
REQ-028 Macro A2D_LD_AVG_EN undefined: all four registers SHALL take rd_data[11:0] directly.
REQ-029 With A2D_LD_AVG_EN defined, the first conversion after reset SHALL average against 12'h000.

Verification
REQ-030 Reset, then nxt pulse with SPI model returning 16'h0ABC -> wrt pulses twice, cmd=16'h0000, lft_ld=12'hABC, cnv_cmplt pulses once.
REQ-031 Four nxt conversions returning 12'h111, 12'h222, 12'h333, 12'h444 -> cmd 16'h0000, 16'h2000, 16'h2800, 16'h3000; registers 111/222/333/444; fifth nxt uses cmd 16'h0000 (wrap).
REQ-032 nxt pulsed during CMD and READ -> no extra wrt; exactly one cnv_cmplt per accepted nxt.
REQ-033 rst asserted in GAP, late done pulse after release -> state IDLE, all readings 0, no cnv_cmplt.
REQ-034 A2D_LD_AVG_EN defined, two lft conversions of 12'hFFF -> lft_ld 12'h7FF then 12'hBFF; undefined -> 12'hFFF both.
REQ-035 rd_data=16'hF123 -> register gets 12'h123 (upper bits discarded).

Source files
------------

// File: rtl/a2d_intf.sv
// Round-robin A2D sequencer: two SPI transactions per conversion (command, then read).
// Optional build macro A2D_LD_AVG_EN averages new lft_ld/rght_ld readings with the previous ones.
module a2d_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2,
    READ = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  ptr_r;
  logic [2:0]  chnl_s;
  logic        start_s;
  logic        issue_rd_s;
  logic        finish_s;
  logic        wrt_r;
  logic        cnv_cmplt_r;
  logic [15:0] cmd_r;
  logic [11:0] lft_r;
  logic [11:0] rght_r;
  logic [11:0] steer_r;
  logic [11:0] batt_r;
  logic [11:0] rd_val_s;
  logic [11:0] lft_nxt_s;
  logic [11:0] rght_nxt_s;
  logic        unused_rd_hi_s;

  assign rd_val_s       = rd_data[11:0];
  assign unused_rd_hi_s = ^rd_data[15:12];

`ifdef A2D_LD_AVG_EN
  function automatic logic [11:0] avg12(input logic [11:0] old_v, input logic [11:0] new_v);
    logic [12:0] sum_v;
    sum_v = {1'b0, old_v} + {1'b0, new_v};
    return sum_v[12:1];
  endfunction

  assign lft_nxt_s  = avg12(lft_r, rd_val_s);
  assign rght_nxt_s = avg12(rght_r, rd_val_s);
`else
  assign lft_nxt_s  = rd_val_s;
  assign rght_nxt_s = rd_val_s;
`endif

  // Pointer to physical channel number
  always_comb begin
    chnl_s = 3'd0;
    case (ptr_r)
      2'd0:    chnl_s = 3'd0;
      2'd1:    chnl_s = 3'd4;
      2'd2:    chnl_s = 3'd5;
      2'd3:    chnl_s = 3'd6;
      default: chnl_s = 3'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and transfer strobes; nxt is only honoured in IDLE, done only in CMD/READ
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    issue_rd_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (nxt) begin
          next_state_s = CMD;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      CMD: begin
        if (done) begin
          next_state_s = GAP;
        end else begin
          next_state_s = CMD;
        end
      end
      GAP: begin
        next_state_s = READ;
        issue_rd_s   = 1'b1;
      end
      READ: begin
        if (done) begin
          next_state_s = IDLE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = READ;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered SPI strobes, command word, completion pulse and channel pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wrt_r       <= 1'b0;
      cnv_cmplt_r <= 1'b0;
      cmd_r       <= 16'h0000;
      ptr_r       <= 2'd0;
    end else begin
      wrt_r       <= start_s | issue_rd_s;
      cnv_cmplt_r <= finish_s;
      if (start_s) begin
        cmd_r <= {2'b00, chnl_s, 11'h000};
      end
      if (finish_s) begin
        ptr_r <= ptr_r + 2'd1;
      end
    end
  end

  // Reading registers: only the addressed one updates on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_r   <= 12'h000;
      rght_r  <= 12'h000;
      steer_r <= 12'h000;
      batt_r  <= 12'h000;
    end else if (finish_s) begin
      case (ptr_r)
        2'd0:    lft_r   <= lft_nxt_s;
        2'd1:    rght_r  <= rght_nxt_s;
        2'd2:    steer_r <= rd_val_s;
        2'd3:    batt_r  <= rd_val_s;
        default: lft_r   <= lft_r;
      endcase
    end
  end

  assign wrt       = wrt_r;
  assign cnv_cmplt = cnv_cmplt_r;
  assign cmd       = cmd_r;
  assign lft_ld    = lft_r;
  assign rght_ld   = rght_r;
  assign steer_pot = steer_r;
  assign batt      = batt_r;

endmodule

// File: tb/tb_a2d_intf.sv
// Randomized bench for a2d_intf against a channel/reading reference model.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        cnv_cmplt;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wrt_cnt  = 0;
  int cc_cnt   = 0;

  logic [11:0] exp_rd [4];
  int          exp_ptr;
  int          chan_tab [4] = '{0, 4, 5, 6};

`ifdef A2D_LD_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  a2d_intf dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .cnv_cmplt (cnv_cmplt)
  );

  always #10 clk = ~clk;

  // Pulse counters (sampled pre-update at the active edge)
  always @(posedge clk) begin
    if (wrt === 1'b1) wrt_cnt <= wrt_cnt + 1;
    if (cnv_cmplt === 1'b1) cc_cnt <= cc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [11:0] model_upd(input int idx, input logic [11:0] old_v,
                                            input logic [11:0] new_v);
    int avg;
    avg = (int'(old_v) + int'(new_v)) / 2;
    return (AVG_ON && idx < 2) ? avg[11:0] : new_v;
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, "_lft"},   {4'h0, lft_ld},    {4'h0, exp_rd[0]});
    check_eq({tag, "_rght"},  {4'h0, rght_ld},   {4'h0, exp_rd[1]});
    check_eq({tag, "_steer"}, {4'h0, steer_pot}, {4'h0, exp_rd[2]});
    check_eq({tag, "_batt"},  {4'h0, batt},      {4'h0, exp_rd[3]});
  endtask

  task automatic do_reset(input bit with_nxt, input bit with_done);
    rst  = 1'b1;
    nxt  = with_nxt;
    done = with_done;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    nxt  = 1'b0;
    done = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) exp_rd[i] = 12'h000;
    check_eq("rst_wrt", {15'd0, wrt}, 16'd0);
    check_eq("rst_cnv_cmplt", {15'd0, cnv_cmplt}, 16'd0);
    check_eq("rst_cmd", cmd, 16'h0000);
    check_regs("rst");
    @(negedge clk);
    check_eq("rst_dom_wrt", {15'd0, wrt}, 16'd0);
  endtask

  // One full conversion; called at a negedge with the DUT idle
  task automatic conv(input logic [15:0] data, input int lat1, input int lat2,
                      input bit xnxt, input bit idle_done, input bit gap_done);
    int w0, c0;
    logic [15:0] exp_cmd;
    exp_cmd = {2'b00, 3'(chan_tab[exp_ptr]), 11'h000};
    w0 = wrt_cnt;
    c0 = cc_cnt;
    nxt  = 1'b1;
    done = idle_done;
    @(negedge clk);
    nxt  = 1'b0;
    done = 1'b0;
    check_eq("wrt_cmd", {15'd0, wrt}, 16'd1);
    check_eq("cmd", cmd, exp_cmd);
    for (int i = 0; i < lat1; i++) begin
      if (xnxt && i == 0) nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
    end
    done = 1'b1;
    @(negedge clk);
    done = gap_done;
    check_eq("wrt_gap", {15'd0, wrt}, 16'd0);
    @(negedge clk);
    done = 1'b0;
    check_eq("wrt_read", {15'd0, wrt}, 16'd1);
    check_eq("cmd_hold", cmd, exp_cmd);
    for (int i = 0; i < lat2; i++) begin
      if (xnxt && i == 0) nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
    end
    rd_data = data;
    done    = 1'b1;
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'($urandom);
    exp_rd[exp_ptr] = model_upd(exp_ptr, exp_rd[exp_ptr], data[11:0]);
    exp_ptr = (exp_ptr + 1) % 4;
    check_eq("cnv_cmplt", {15'd0, cnv_cmplt}, 16'd1);
    check_regs("conv");
    @(negedge clk);
    check_eq("cnv_cmplt_once", {15'd0, cnv_cmplt}, 16'd0);
    check_eq("wrt_pulses", 16'(wrt_cnt - w0), 16'd2);
    check_eq("cc_pulses", 16'(cc_cnt - c0), 16'd1);
    check_eq("cmd_between", cmd, exp_cmd);
  endtask

  initial begin
    int w0, c0;
    rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = 16'h0000;
    @(negedge clk);

    do_reset(1'b0, 1'b0);
    conv(16'h0ABC, 2, 2, 1'b0, 1'b0, 1'b0);

    do_reset(1'b1, 1'b1);
    conv(16'h0111, 1, 1, 1'b0, 1'b0, 1'b0);
    conv(16'h0222, 3, 0, 1'b0, 1'b0, 1'b0);
    conv(16'h0333, 2, 4, 1'b1, 1'b0, 1'b0);
    conv(16'h0444, 4, 2, 1'b1, 1'b1, 1'b1);
    conv(16'h0555, 1, 1, 1'b0, 1'b0, 1'b0);
    conv(16'hF123, 2, 3, 1'b0, 1'b0, 1'b0);

    // done while idle must not start anything
    w0 = wrt_cnt; c0 = cc_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_done_wrt", 16'(wrt_cnt - w0), 16'd0);
    check_eq("idle_done_cc", 16'(cc_cnt - c0), 16'd0);
    check_regs("idle_done");

    do_reset(1'b0, 1'b0);
    conv(16'h0FFF, 2, 2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) conv(16'($urandom), 1, 1, 1'b0, 1'b0, 1'b0);
    conv(16'h0FFF, 2, 2, 1'b0, 1'b0, 1'b0);

    // reset during GAP, then a late done after release
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) exp_rd[i] = 12'h000;
    w0 = wrt_cnt; c0 = cc_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_wrt", 16'(wrt_cnt - w0), 16'd0);
    check_eq("abort_cc", 16'(cc_cnt - c0), 16'd0);
    check_eq("abort_cmd", cmd, 16'h0000);
    check_regs("abort");
    conv(16'($urandom), 2, 2, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      conv(16'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 5)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
